line_win_checker: RTL
=====================

Name: line_win_checker

Overview:
- Parametrised successor to the fixed horizontal/overall win check.
- After each placed stone, scans the board memory outward from the last-placed cell in up to four directions (horizontal, vertical, diagonal, anti-diagonal). Reports whether the current player has WIN_LEN or more stones in a row.
- Sits between the game FSM (start pulse, pointer, current player) and the board-memory read port. It is the only reader of that port during a check.

Parameters:
BOARD_W, 16, board columns; power of two
BOARD_H, 16, board rows
ADDR_W, 8, cell address width; address = row*BOARD_W + col; must be >= log2(BOARD_W*BOARD_H)
CELL_W, 2, bits per cell; 0 = empty, other values = player id
WIN_LEN, 5, stones in a row needed to win; range 2..min(BOARD_W,BOARD_H)
DIAG_EN, 1, 1 = check all four directions; 0 = horizontal and vertical only

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
active  in  1  start pulse; sampled only in IDLE
pointer  in  ADDR_W  address of the last-placed cell
player  in  CELL_W  player id to match
rd_addr  out  ADDR_W  board-memory read address
rd_data  in  CELL_W  board-memory read data, valid the cycle after rd_addr is presented
busy  out  1  high from the cycle after active is accepted until done
done  out  1  one-cycle pulse at the end of a check
success  out  1  a line of WIN_LEN or more was found; held until next accepted active
fail  out  1  no winning line; held until next accepted active
max_run  out  clog2(WIN_LEN+1)  longest run seen, saturating at WIN_LEN; held with success/fail

Behaviour:
- Reset (reset==0 at clk edge):
  - state=IDLE; rd_addr, busy, done, success, fail, max_run all 0.
  - Reset asserted mid-scan aborts the scan immediately. No done pulse is produced.
- IDLE, active==1:
  - Latch pointer as col = pointer[log2(BOARD_W)-1:0] and row = pointer / BOARD_W. Latch player.
  - Clear success, fail, max_run; set busy; go to ORG_ISSUE.
  - active while busy is ignored.
- ORG_ISSUE: rd_addr = pointer; go to ORG_CHK.
- ORG_CHK: compare rd_data with player.
  - Mismatch (including empty): fail=1, max_run=0, go to FINISH.
  - Match: run=1, dir=H, side=+, go to ADV.
- ADV: compute the next coordinate = last coordinate + side*step(dir).
  - Steps: H (+1,0); V (0,+1); D (+1,+1); A (+1,-1), given as (col,row).
  - If the coordinate is in-board and this side has fewer than WIN_LEN-1 reads: drive rd_addr, go to CHK.
  - Otherwise, on side +: switch to side - from the origin and stay in ADV.
  - Otherwise, on side -: go to DIR_END.
- CHK:
  - rd_data==player: run++; go to ADV.
  - Else: end this side as in ADV.
- DIR_END:
  - max_run = max(max_run, min(run, WIN_LEN)).
  - run >= WIN_LEN: success=1, go to FINISH (early out; remaining directions are skipped).
  - Else, if directions remain: next dir (order H, V, D, A; D and A skipped when DIAG_EN=0), run=1, side=+, go to ADV.
  - Else: fail=1, go to FINISH.
- FINISH: done=1 for exactly one cycle; busy=0; go to IDLE.
- Overline: a run longer than WIN_LEN still counts as success. Each side reads at most WIN_LEN-1 cells.
- Boundaries:
  - Column wrap is never treated as adjacency. col+1==BOARD_W or col-1<0 ends the side.
  - Same rule for rows.
- Latency: ≤ 80 cycles from accepted active to done for the default parameters.
- Data-stable assumption: the board is not written while busy=1. Behaviour is undefined otherwise.
- success and fail are mutually exclusive. Both are 0 while busy.

Test Plan:
- Empty board, pointer=0x00, player=1 → done within 3 cycles of active; fail=1, success=0, max_run=0.
- Player-1 stones at row 3, cols 4..8; pointer=0x36 (middle) → success=1, max_run=5. Exactly one done pulse; no rd_addr outside row 3 after the H direction ends.
- Four stones at row 0 cols 12..15 plus player-1 stone at row 1 col 0; pointer=0x0F → fail=1, max_run=4. rd_addr never equals 0x10 during the H scan (no wrap).
- Anti-diagonal (col,row) = (2,6),(3,5),(4,4),(5,3),(6,2), pointer=0x44:
  - DIAG_EN=1 → success=1.
  - Re-run with DIAG_EN=0 → fail=1.
- Six in a column, rows 5..10 col 7, pointer=0x57 → success=1; max_run=5 (saturated).
- Mid-scan reset: assert reset=0 for 1 cycle at cycle 10 of a check → all outputs 0 the next cycle, no done pulse. A new active then completes normally.

Source files
------------

// File: rtl/line_win_checker_if.sv
// Bundle between the game FSM / board memory (master side) and the
// line_win_checker (slave side).
//   active   : start pulse, sampled only while the checker is idle
//   pointer  : address of the last-placed cell (row*BOARD_W + col)
//   player   : player id whose line is being checked
//   rd_addr  : board-memory read address driven by the checker
//   rd_data  : board-memory read data for the presented rd_addr
//   busy     : check in progress
//   done     : one-cycle pulse when the check finishes
//   success  : a line of WIN_LEN or more was found (held)
//   fail     : no winning line (held)
//   max_run  : longest run seen, saturating at WIN_LEN (held)
interface line_win_checker_if #(
    parameter int ADDR_W = 8,
    parameter int CELL_W = 2,
    parameter int RUN_W  = 3
);
    logic              active;
    logic [ADDR_W-1:0] pointer;
    logic [CELL_W-1:0] player;
    logic [ADDR_W-1:0] rd_addr;
    logic [CELL_W-1:0] rd_data;
    logic              busy;
    logic              done;
    logic              success;
    logic              fail;
    logic [RUN_W-1:0]  max_run;

    modport master (
        output active, pointer, player, rd_data,
        input  rd_addr, busy, done, success, fail, max_run
    );

    modport slave (
        input  active, pointer, player, rd_data,
        output rd_addr, busy, done, success, fail, max_run
    );
endinterface

// File: rtl/line_win_checker.sv
// Line-win checker: after a stone is placed, walks the board memory outward
// from the last-placed cell along horizontal, vertical and (optionally) both
// diagonals, and reports whether the current player owns WIN_LEN or more
// cells in a row through that cell.
//
// Ports:
//   clk    : system clock
//   reset  : synchronous, active-low reset
//   bus    : line_win_checker_if.slave (start/pointer/player in, board read
//            port, busy/done/success/fail/max_run out)
//
// The board read port is combinational from the checker's point of view:
// data for the address registered in one cycle is compared at the end of the
// following cycle. Each direction is scanned as two sides (+ then -) that
// both restart from the origin; each side reads at most WIN_LEN-1 cells and
// stops at the board edge, so row/column wrap is never treated as adjacent.
module line_win_checker #(
    parameter int BOARD_W = 16,
    parameter int BOARD_H = 16,
    parameter int ADDR_W  = 8,
    parameter int CELL_W  = 2,
    parameter int WIN_LEN = 5,
    parameter int DIAG_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    line_win_checker_if.slave bus
);

    localparam int COL_W  = $clog2(BOARD_W);
    localparam int ROW_W  = $clog2(BOARD_H);
    localparam int RUN_W  = $clog2(WIN_LEN + 1);
    localparam int CNT_W  = $clog2(WIN_LEN);
    localparam int RUNC_W = $clog2(2 * WIN_LEN);
    localparam int CW2    = COL_W + 2;
    localparam int RW2    = ROW_W + 2;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] ORG_ISSUE = 3'd1;
    localparam logic [2:0] ORG_CHK   = 3'd2;
    localparam logic [2:0] ADV       = 3'd3;
    localparam logic [2:0] CHK       = 3'd4;
    localparam logic [2:0] DIR_END   = 3'd5;
    localparam logic [2:0] FINISH    = 3'd6;

    localparam logic [1:0] DIR_H = 2'd0;
    localparam logic [1:0] DIR_V = 2'd1;
    localparam logic [1:0] DIR_D = 2'd2;
    localparam logic [1:0] DIR_A = 2'd3;
    localparam logic [1:0] LAST_DIR = (DIAG_EN != 0) ? DIR_A : DIR_V;

    localparam logic [CNT_W-1:0]      SIDE_MAX = CNT_W'(WIN_LEN - 1);
    localparam logic [RUNC_W-1:0]     RUN_WIN  = RUNC_W'(WIN_LEN);
    localparam logic signed [CW2-1:0] COL_LIM  = CW2'(BOARD_W);
    localparam logic signed [RW2-1:0] ROW_LIM  = RW2'(BOARD_H);

    // Run length clipped to WIN_LEN for the reported max_run.
    function automatic logic [RUN_W-1:0] sat_run(input logic [RUNC_W-1:0] r);
        if (r >= RUN_WIN)
            return RUN_W'(WIN_LEN);
        return r[RUN_W-1:0];
    endfunction

    function automatic logic [ADDR_W-1:0] make_addr(input logic [ROW_W-1:0] r,
                                                    input logic [COL_W-1:0] c);
        return ADDR_W'({r, c});
    endfunction

    logic [2:0]        state;
    logic [1:0]        dir;
    logic              side;        // 0 = walking +step, 1 = walking -step
    logic [CNT_W-1:0]  side_cnt;    // cells read on the current side
    logic [COL_W-1:0]  org_col;
    logic [ROW_W-1:0]  org_row;
    logic [COL_W-1:0]  cur_col;
    logic [ROW_W-1:0]  cur_row;
    logic [CELL_W-1:0] match_id;
    logic [RUNC_W-1:0] run;
    logic [ADDR_W-1:0] rd_addr_r;
    logic              busy_r;
    logic              done_r;
    logic              success_r;
    logic              fail_r;
    logic [RUN_W-1:0]  max_run_r;

    logic signed [1:0]     step_col;
    logic signed [1:0]     step_row;
    logic signed [1:0]     dcol;
    logic signed [1:0]     drow;
    logic signed [CW2-1:0] nxt_col;
    logic signed [RW2-1:0] nxt_row;
    logic                  in_board;
    logic                  can_read;
    logic                  cell_match;
    logic                  won;
    logic [RUN_W-1:0]      run_sat;
    logic [RUN_W-1:0]      max_nxt;

    always_comb begin
        step_col = 2'sd1;
        step_row = 2'sd0;
        case (dir)
            DIR_V: begin
                step_col = 2'sd0;
                step_row = 2'sd1;
            end
            DIR_D: begin
                step_col = 2'sd1;
                step_row = 2'sd1;
            end
            DIR_A: begin
                step_col = 2'sd1;
                step_row = -2'sd1;
            end
            default: ;
        endcase
    end

    assign dcol = side ? -step_col : step_col;
    assign drow = side ? -step_row : step_row;

    // Coordinates carry a sign bit and one guard bit so that stepping off
    // either edge shows up as negative or >= the board size, never as wrap.
    assign nxt_col = $signed({2'b00, cur_col}) + CW2'(dcol);
    assign nxt_row = $signed({2'b00, cur_row}) + RW2'(drow);

    assign in_board   = !nxt_col[CW2-1] && (nxt_col < COL_LIM) &&
                        !nxt_row[RW2-1] && (nxt_row < ROW_LIM);
    assign can_read   = in_board && (side_cnt < SIDE_MAX);
    assign cell_match = (bus.rd_data == match_id);
    assign won        = (run >= RUN_WIN);
    assign run_sat    = sat_run(run);
    assign max_nxt    = (run_sat > max_run_r) ? run_sat : max_run_r;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            dir       <= DIR_H;
            side      <= 1'b0;
            side_cnt  <= '0;
            rd_addr_r <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            success_r <= 1'b0;
            fail_r    <= 1'b0;
            max_run_r <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.active) begin
                        org_col   <= bus.pointer[COL_W-1:0];
                        org_row   <= bus.pointer[COL_W +: ROW_W];
                        match_id  <= bus.player;
                        success_r <= 1'b0;
                        fail_r    <= 1'b0;
                        max_run_r <= '0;
                        busy_r    <= 1'b1;
                        state     <= ORG_ISSUE;
                    end
                end
                ORG_ISSUE: begin
                    rd_addr_r <= make_addr(org_row, org_col);
                    cur_col   <= org_col;
                    cur_row   <= org_row;
                    state     <= ORG_CHK;
                end
                ORG_CHK: begin
                    if (cell_match) begin
                        run      <= RUNC_W'(1);
                        dir      <= DIR_H;
                        side     <= 1'b0;
                        side_cnt <= '0;
                        state    <= ADV;
                    end else begin
                        fail_r    <= 1'b1;
                        max_run_r <= '0;
                        busy_r    <= 1'b0;
                        done_r    <= 1'b1;
                        state     <= FINISH;
                    end
                end
                ADV: begin
                    if (can_read) begin
                        cur_col   <= nxt_col[COL_W-1:0];
                        cur_row   <= nxt_row[ROW_W-1:0];
                        rd_addr_r <= make_addr(nxt_row[ROW_W-1:0], nxt_col[COL_W-1:0]);
                        side_cnt  <= side_cnt + CNT_W'(1);
                        state     <= CHK;
                    end else if (!side) begin
                        // + side exhausted: walk the - side from the origin
                        side     <= 1'b1;
                        side_cnt <= '0;
                        cur_col  <= org_col;
                        cur_row  <= org_row;
                    end else begin
                        state <= DIR_END;
                    end
                end
                CHK: begin
                    if (cell_match) begin
                        run   <= run + RUNC_W'(1);
                        state <= ADV;
                    end else if (!side) begin
                        side     <= 1'b1;
                        side_cnt <= '0;
                        cur_col  <= org_col;
                        cur_row  <= org_row;
                        state    <= ADV;
                    end else begin
                        state <= DIR_END;
                    end
                end
                DIR_END: begin
                    max_run_r <= max_nxt;
                    if (won) begin
                        success_r <= 1'b1;
                        busy_r    <= 1'b0;
                        done_r    <= 1'b1;
                        state     <= FINISH;
                    end else if (dir != LAST_DIR) begin
                        dir      <= dir + 2'd1;
                        run      <= RUNC_W'(1);
                        side     <= 1'b0;
                        side_cnt <= '0;
                        cur_col  <= org_col;
                        cur_row  <= org_row;
                        state    <= ADV;
                    end else begin
                        fail_r <= 1'b1;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= FINISH;
                    end
                end
                FINISH: begin
                    // done was raised on entry; this cycle only returns to IDLE
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.rd_addr = rd_addr_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.success = success_r;
    assign bus.fail    = fail_r;
    assign bus.max_run = max_run_r;

endmodule
